// File: rtl/funnel_pack.sv
// funnel_pack: upstream packer for the data funnel.
//
// Gathers a valid/ready stream of narrow chunks into one wide word of CHUNKS
// chunks and presents it on the funnel's wide target port together with the
// per-word config byte. A word closes after CHUNKS beats or early on t_last.
// One output register plus one hold register give full-rate packing with
// backpressure: while the output is stalled, one complete word may wait in
// the hold register and the input is stalled behind it.
//
// Ports:
//   clk      in   clock
//   reset    in   synchronous, active-high reset
//   t_dat    in   narrow input chunk (CHUNK_W bits)
//   t_cfg    in   config byte, captured on the first beat of each word
//   t_last   in   frame end, closes the current word early
//   t_valid  in   input beat valid
//   t_ready  out  input beat accepted when t_valid && t_ready
//   i_dat    out  packed wide word, chunk k at [(k+1)*CHUNK_W-1 : k*CHUNK_W]
//   i_cfg    out  config byte captured for the presented word
//   i_fill   out  number of real chunks in i_dat (1..CHUNKS)
//   i_valid  out  wide word valid
//   i_ready  in   downstream accepts when i_valid && i_ready
//   ovf      out  sticky flag: a pending beat was withdrawn before acceptance
module funnel_pack #(
    parameter int CHUNK_W = 128,
    parameter int CHUNKS  = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [CHUNK_W-1:0]          t_dat,
    input  logic [7:0]                  t_cfg,
    input  logic                        t_last,
    input  logic                        t_valid,
    output logic                        t_ready,
    output logic [CHUNKS*CHUNK_W-1:0]   i_dat,
    output logic [7:0]                  i_cfg,
    output logic [$clog2(CHUNKS):0]     i_fill,
    output logic                        i_valid,
    input  logic                        i_ready,
    output logic                        ovf
);

    localparam int CNT_W  = $clog2(CHUNKS);
    localparam int WORD_W = CHUNKS * CHUNK_W;

    typedef enum logic {
        S_FILL,
        S_HOLD
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [WORD_W-1:0]   r_acc;
    logic [7:0]          r_acc_cfg;

    logic [WORD_W-1:0]   r_hold_dat;
    logic [7:0]          r_hold_cfg;
    logic [CNT_W:0]      r_hold_fill;

    logic                r_valid;
    logic [WORD_W-1:0]   r_dat;
    logic [7:0]          r_cfg;
    logic [CNT_W:0]      r_fill;

    logic                r_ovf;
    logic                r_pend;

    logic                w_tready;
    logic                w_accept;
    logic                w_close;
    logic                w_free;
    logic [WORD_W-1:0]   w_word;
    logic [7:0]          w_cfg;
    logic [CNT_W:0]      w_fill;

    assign w_tready = (r_state == S_FILL);
    assign w_accept = t_valid && w_tready;
    assign w_close  = w_accept && (t_last || (r_cnt == CNT_W'(CHUNKS - 1)));
    assign w_free   = !r_valid || i_ready;

    // The accumulator is cleared on every close, so slices above the current
    // beat are already zero and a short word needs no extra masking.
    always_comb begin
        w_word = r_acc;
        w_word[int'(r_cnt) * CHUNK_W +: CHUNK_W] = t_dat;
        w_cfg  = (r_cnt == '0) ? t_cfg : r_acc_cfg;
        w_fill = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FILL;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_acc_cfg <= '0;
            r_valid   <= 1'b0;
            r_dat     <= '0;
            r_cfg     <= '0;
            r_fill    <= '0;
            r_ovf     <= 1'b0;
            r_pend    <= 1'b0;
        end else begin
            // A beat offered but not taken must stay offered until accepted.
            r_pend <= t_valid && !w_tready;
            if (r_pend && !t_valid) begin
                r_ovf <= 1'b1;
            end

            // Handshake empties the slot unless a load below refills it.
            if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                S_FILL: begin
                    if (w_accept) begin
                        if (w_close) begin
                            r_cnt     <= '0;
                            r_acc     <= '0;
                            r_acc_cfg <= '0;
                            if (w_free) begin
                                r_valid <= 1'b1;
                                r_dat   <= w_word;
                                r_cfg   <= w_cfg;
                                r_fill  <= w_fill;
                            end else begin
                                r_hold_dat  <= w_word;
                                r_hold_cfg  <= w_cfg;
                                r_hold_fill <= w_fill;
                                r_state     <= S_HOLD;
                            end
                        end else begin
                            r_cnt     <= r_cnt + 1'b1;
                            r_acc     <= w_word;
                            r_acc_cfg <= w_cfg;
                        end
                    end
                end
                S_HOLD: begin
                    if (w_free) begin
                        r_valid <= 1'b1;
                        r_dat   <= r_hold_dat;
                        r_cfg   <= r_hold_cfg;
                        r_fill  <= r_hold_fill;
                        r_state <= S_FILL;
                    end
                end
                default: r_state <= S_FILL;
            endcase
        end
    end

    assign t_ready = w_tready;
    assign i_dat   = r_dat;
    assign i_cfg   = r_cfg;
    assign i_fill  = r_fill;
    assign i_valid = r_valid;
    assign ovf     = r_ovf;

endmodule

// File: tb/tb_funnel_pack.sv
module tb_funnel_pack;

    localparam int CHUNK_W = 128;
    localparam int CHUNKS  = 4;
    localparam int WORD_W  = CHUNK_W * CHUNKS;

    logic                clk = 1'b0;
    logic                reset;
    logic [CHUNK_W-1:0]  t_dat;
    logic [7:0]          t_cfg;
    logic                t_last;
    logic                t_valid;
    logic                t_ready;
    logic [WORD_W-1:0]   i_dat;
    logic [7:0]          i_cfg;
    logic [2:0]          i_fill;
    logic                i_valid;
    logic                i_ready;
    logic                ovf;

    funnel_pack #(.CHUNK_W(CHUNK_W), .CHUNKS(CHUNKS)) dut (
        .clk     (clk),
        .reset   (reset),
        .t_dat   (t_dat),
        .t_cfg   (t_cfg),
        .t_last  (t_last),
        .t_valid (t_valid),
        .t_ready (t_ready),
        .i_dat   (i_dat),
        .i_cfg   (i_cfg),
        .i_fill  (i_fill),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WORD_W-1:0] dat;
        logic [7:0]        cfg;
        logic [2:0]        fill;
    } word_t;

    word_t               exp_q[$];
    logic [CHUNK_W-1:0]  m_chunks[$];
    logic [7:0]          m_cfg;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [WORD_W-1:0] obs, input logic [WORD_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: a word is the list of accepted chunks, closed by
    // t_last or by reaching CHUNKS entries; unused slices are zero.
    task automatic model_beat(input logic [CHUNK_W-1:0] d, input logic [7:0] c, input logic l);
        word_t w;
        if (m_chunks.size() == 0) m_cfg = c;
        m_chunks.push_back(d);
        if (l || m_chunks.size() == CHUNKS) begin
            w.dat = '0;
            for (int k = 0; k < m_chunks.size(); k++) w.dat[k*CHUNK_W +: CHUNK_W] = m_chunks[k];
            w.cfg  = m_cfg;
            w.fill = 3'(m_chunks.size());
            exp_q.push_back(w);
            m_chunks.delete();
        end
    endtask

    // One clock: record handshakes seen before the edge, then advance.
    task automatic tick();
        word_t e;
        if (!reset) begin
            if (i_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_word", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_dat", i_dat, e.dat);
                    chk("sb_cfg", i_cfg, e.cfg);
                    chk("sb_fill", i_fill, e.fill);
                end
            end
            if (t_valid && t_ready) model_beat(t_dat, t_cfg, t_last);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        t_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        exp_q.delete();
        m_chunks.delete();
    endtask

    // Offer one beat until accepted; t_valid is left high for the caller.
    task automatic send_beat(input logic [CHUNK_W-1:0] d, input logic [7:0] c, input logic l);
        logic a;
        bit   done;
        done    = 0;
        t_valid = 1'b1;
        t_dat   = d;
        t_cfg   = c;
        t_last  = l;
        for (int n = 0; n < 50 && !done; n++) begin
            a = t_ready;
            tick();
            if (a) done = 1;
        end
        if (!done) chk("send_timeout", 1'b0, 1'b1);
    endtask

    task automatic drain();
        t_valid = 1'b0;
        i_ready = 1'b1;
        for (int n = 0; n < 30 && (exp_q.size() != 0 || i_valid); n++) tick();
        chk("drain_empty", 32'(exp_q.size()), 0);
        chk("drain_ivalid", i_valid, 1'b0);
    endtask

    logic [CHUNK_W-1:0] bt [12];
    logic [CHUNK_W-1:0] ca, cb, cc;
    logic               a, pend;
    int                 sent;

    initial begin
        reset   = 1'b1;
        t_dat   = '0;
        t_cfg   = '0;
        t_last  = 1'b0;
        t_valid = 1'b0;
        i_ready = 1'b1;

        // Reset state.
        do_reset();
        chk("rst_ivalid", i_valid, 1'b0);
        chk("rst_idat", i_dat, '0);
        chk("rst_icfg", i_cfg, 8'h00);
        chk("rst_ifill", i_fill, 3'd0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_tready", t_ready, 1'b1);

        // Eight back-to-back beats, downstream always ready.
        for (int i = 0; i < 8; i++) begin
            t_valid = 1'b1;
            t_dat   = CHUNK_W'(i);
            t_cfg   = (i % 4 != 0) ? 8'hEE : ((i < 4) ? 8'h10 : 8'h11);
            t_last  = 1'b0;
            chk("b2b_tready", t_ready, 1'b1);
            tick();
            if (i == 3) begin
                chk("w0_valid", i_valid, 1'b1);
                chk("w0_dat", i_dat, {128'd3, 128'd2, 128'd1, 128'd0});
                chk("w0_fill", i_fill, 3'd4);
                chk("w0_cfg", i_cfg, 8'h10);
            end
            if (i == 7) begin
                chk("w1_dat", i_dat, {128'd7, 128'd6, 128'd5, 128'd4});
                chk("w1_cfg", i_cfg, 8'h11);
            end
        end
        drain();

        // Backpressure: one word presented, one held, input stalled.
        for (int i = 0; i < 12; i++) bt[i] = {$urandom, $urandom, $urandom, $urandom};
        i_ready = 1'b0;
        sent    = 0;
        for (int n = 0; n < 20; n++) begin
            t_valid = 1'b1;
            t_last  = 1'b0;
            t_dat   = bt[sent];
            t_cfg   = 8'($urandom);
            a = t_ready;
            tick();
            if (a && sent < 11) sent++;
        end
        chk("hold_sent", 32'(sent), 8);
        chk("hold_tready", t_ready, 1'b0);
        chk("hold_ivalid", i_valid, 1'b1);
        chk("hold_front", i_dat, {bt[3], bt[2], bt[1], bt[0]});
        i_ready = 1'b1;
        a = t_ready;
        tick();
        if (a) sent++;
        chk("release_tready", t_ready, 1'b1);
        chk("release_front", i_dat, {bt[7], bt[6], bt[5], bt[4]});
        for (int n = 0; n < 20 && sent < 12; n++) begin
            t_dat = bt[sent];
            t_cfg = 8'($urandom);
            a = t_ready;
            tick();
            if (a) sent++;
        end
        chk("release_sent", 32'(sent), 12);
        chk("word2_dat", i_dat, {bt[11], bt[10], bt[9], bt[8]});
        drain();

        // Short word closed by t_last, then a one-chunk word.
        ca = {$urandom, $urandom, $urandom, $urandom};
        cb = {$urandom, $urandom, $urandom, $urandom};
        cc = {$urandom, $urandom, $urandom, $urandom};
        send_beat(ca, 8'h33, 1'b0);
        send_beat(cb, 8'h44, 1'b0);
        send_beat(cc, 8'h55, 1'b1);
        t_valid = 1'b0;
        chk("short_dat", i_dat, {128'd0, cc, cb, ca});
        chk("short_fill", i_fill, 3'd3);
        chk("short_cfg", i_cfg, 8'h33);
        send_beat(ca, 8'h5A, 1'b1);
        t_valid = 1'b0;
        chk("one_dat", i_dat, {384'd0, ca});
        chk("one_fill", i_fill, 3'd1);
        chk("one_cfg", i_cfg, 8'h5A);
        drain();

        // Handshake and new load on the same edge every cycle.
        i_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            t_valid = 1'b1;
            t_last  = 1'b1;
            t_dat   = {$urandom, $urandom, $urandom, $urandom};
            t_cfg   = 8'($urandom);
            ca      = t_dat;
            tick();
            chk("simul_valid", i_valid, 1'b1);
            chk("simul_dat", i_dat, {384'd0, ca});
        end
        drain();

        // Random traffic with random backpressure, protocol kept legal.
        pend = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!pend) begin
                t_valid = ($urandom_range(0, 3) != 0);
                t_dat   = {$urandom, $urandom, $urandom, $urandom};
                t_cfg   = 8'($urandom);
                t_last  = ($urandom_range(0, 4) == 0);
            end
            i_ready = ($urandom_range(0, 3) != 0);
            pend = t_valid && !t_ready;
            tick();
        end
        send_beat({$urandom, $urandom, $urandom, $urandom}, 8'h77, 1'b1);
        drain();
        chk("rand_ovf", ovf, 1'b0);

        // Withdraw a pending beat during HOLD, then reset mid-hold.
        i_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_beat(CHUNK_W'(i + 100), 8'h01, 1'b0);
        chk("ovf_hold_tready", t_ready, 1'b0);
        tick();
        t_valid = 1'b0;
        tick();
        chk("ovf_set", ovf, 1'b1);
        do_reset();
        chk("rst2_ivalid", i_valid, 1'b0);
        chk("rst2_tready", t_ready, 1'b1);
        chk("rst2_ovf", ovf, 1'b0);

        // Reset with two partial beats pending; next word starts at slice 0.
        i_ready = 1'b1;
        send_beat(CHUNK_W'(200), 8'h02, 1'b0);
        send_beat(CHUNK_W'(201), 8'h02, 1'b0);
        do_reset();
        chk("rst3_ivalid", i_valid, 1'b0);
        for (int i = 0; i < 4; i++) send_beat(CHUNK_W'(i + 300), 8'h3C, 1'b0);
        t_valid = 1'b0;
        chk("fresh_dat", i_dat, {128'd303, 128'd302, 128'd301, 128'd300});
        chk("fresh_cfg", i_cfg, 8'h3C);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/funnel_pack.md
Name: funnel_pack

Overview:
- Upstream packer for the data funnel.
- Gathers a valid/ready stream of narrow 128-bit chunks (radix-4, 16-bit complex I/Q) into one wide word of CHUNKS chunks and presents it to the funnel's wide target port.
- Also captures the per-word config byte that rides alongside as the funnel's mode/config input.
- Gives frame-aligned, gap-tolerant input with full-rate throughput and backpressure.

Parameters:
- CHUNK_W, 128, width of one narrow chunk (radix 4 x 2 x 16).
- CHUNKS, 4, chunks per wide word; power of two, at least 2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- t_dat  in  CHUNK_W  narrow input chunk.
- t_cfg  in  8  config byte; sampled on the first accepted beat of each word.
- t_last  in  1  frame end; closes the current word early.
- t_valid  in  1  input beat valid.
- t_ready  out  1  input beat accepted when t_valid and t_ready are both high.
- i_dat  out  CHUNKS*CHUNK_W  packed wide word; chunk k occupies [(k+1)*CHUNK_W-1 : k*CHUNK_W].
- i_cfg  out  8  config byte captured for this word.
- i_fill  out  log2(CHUNKS)+1  number of real chunks in i_dat (1..CHUNKS).
- i_valid  out  1  wide word valid.
- i_ready  in  1  downstream accepts when i_valid and i_ready are both high.
- ovf  out  1  sticky error flag; set if t_valid drops mid-hold (see below). Cleared only by reset.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to FILL; beat count goes to 0.
  - i_valid=0, i_dat=0, i_cfg=0, i_fill=0, ovf=0.
  - t_ready reads 1 in the first cycle after reset deasserts.
  - Reset asserted mid-word or mid-hold discards all partial and held data with no output.
- Chunk placement:
  - The n-th accepted beat of a word (n from 0) writes slice n.
  - Slices not written in a short word read 0.
  - t_cfg is captured at n=0 only; the value on later beats is ignored.
- Word close: a word closes when the accepted beat has n==CHUNKS-1, or t_last=1 (either condition).
  - i_fill = n+1.
  - The count returns to 0.
- Output slot: a single register.
  - The slot is "free" this cycle if !i_valid, or if i_valid and i_ready are both high.
- FILL state:
  - t_ready=1.
  - Closing beat with the slot free: the word (including the current t_dat) loads the output on the same edge. i_valid=1 the next cycle, giving one-cycle latency from the closing beat.
  - Closing beat with the slot not free: the word moves to the hold register and the state becomes HOLD.
- HOLD state:
  - t_ready=0.
  - When the slot is free, the hold register loads the output and the state returns to FILL, so t_ready=1 the next cycle.
- Throughput:
  - With i_ready held at 1, back-to-back beats pack with no bubbles: one word every CHUNKS cycles, no t_ready drop.
  - With i_ready=0, at most one complete word is held plus one in the output. Input stalls; nothing is dropped.
- Output stability: i_dat, i_cfg and i_fill are stable while i_valid=1 and i_ready=0. i_valid drops only after a handshake.
- Simultaneous events: an output handshake and a new load on the same edge gives i_valid staying at 1 with the new word (no bubble).
- t_last on beat 0 closes a 1-chunk word: i_fill=1, upper slices 0.
- ovf: t_valid dropping while t_ready=0 does not lose data, but a t_valid/t_ready protocol violation (t_valid deasserting during HOLD before acceptance) sets ovf.
- Width rules:
  - Beat count is log2(CHUNKS) bits and wraps to 0 on close.
  - i_fill is one bit wider so it can hold CHUNKS.

Test Plan:
- Reset, then 8 back-to-back beats t_dat=chunk index 0..7 with a per-word t_cfg, i_ready=1 -> two words at cycles 4 and 8 after the first beat. Word0 slices = 0,1,2,3, i_fill=4, i_cfg = word0's byte. t_ready stays 1 throughout.
- i_ready=0, stream 12 beats -> the first word is presented and the second is held. t_ready=0 after beat 8. Raise i_ready -> words emitted in order, t_ready returns the cycle after the hold moves, beats 8..11 form word 2.
- 3 beats (A, B, C) with t_last on C -> i_dat slices = A, B, C, 0, i_fill=3. The next word starts at slice 0.
- t_last on the first beat with t_cfg=0x5A -> i_fill=1, i_cfg=0x5A, slices 1..3 = 0.
- Output handshake and a new closing beat on the same edge -> i_valid remains 1 and the new data appears the next cycle; no lost or duplicated word (scoreboard).
- Reset asserted mid-hold with 2 partial beats -> next cycle i_valid=0, t_ready=1, ovf=0. A fresh word packs from slice 0.
